// File: rtl/scr1_ram_width_bridge.sv
// +--------------------------------------------------------------------------+
// | scr1_ram_width_bridge: 32-bit Avalon-MM master to 64-bit single-port RAM  |
// | with write lane steering and a one-entry coherent read buffer.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module scr1_ram_width_bridge #(
    parameter int READ_BUFFER = 1,
    parameter int RAM_AW      = 13
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [RAM_AW:0]   s_address,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [3:0]        s_byteenable,
    input  logic [31:0]       s_writedata,
    output logic [31:0]       s_readdata,
    output logic              s_readdatavalid,
    output logic              s_waitrequest,
    output logic [RAM_AW-1:0] m_address,
    output logic [7:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [63:0]       m_writedata,
    output logic              m_clken,
    input  logic [63:0]       m_readdata
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              buf_valid_q, buf_valid_d;
    logic [RAM_AW-1:0] buf_tag_q, buf_tag_d;
    logic [63:0]       buf_data_q, buf_data_d;
    logic              pend_half_q, pend_half_d;
    logic [RAM_AW-1:0] pend_tag_q, pend_tag_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic [RAM_AW-1:0] word_addr;
    logic              half_sel;
    logic [7:0]        lane_be;
    logic [63:0]       lane_mask;
    logic [63:0]       wdata_wide;
    logic              tag_hit;
    logic              rd_hit;
    logic              ram_cs;
    logic              ram_we;
    logic [7:0]        ram_be;

    assign word_addr  = s_address[RAM_AW:1];
    assign half_sel   = s_address[0];
    assign lane_be    = half_sel ? {s_byteenable, 4'b0000} : {4'b0000, s_byteenable};
    assign wdata_wide = {s_writedata, s_writedata};
    assign tag_hit    = buf_valid_q && (buf_tag_q == word_addr);
    assign rd_hit     = tag_hit && (READ_BUFFER != 0);

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 8; i++) begin
            lane_mask[i*8 +: 8] = {8{lane_be[i]}};
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        pend_half_d = pend_half_q;
        pend_tag_d  = pend_tag_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_be      = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (s_write) begin
                    ram_cs = 1'b1;
                    ram_we = 1'b1;
                    ram_be = lane_be;
                    // Write-through keeps the buffered copy coherent with RAM.
                    if (tag_hit) begin
                        buf_data_d = (buf_data_q & ~lane_mask) | (wdata_wide & lane_mask);
                    end
                end else if (s_read) begin
                    if (rd_hit) begin
                        rdata_d  = half_sel ? buf_data_q[63:32] : buf_data_q[31:0];
                        rvalid_d = 1'b1;
                    end else begin
                        ram_cs      = 1'b1;
                        pend_half_d = half_sel;
                        pend_tag_d  = word_addr;
                        state_d     = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                buf_data_d  = m_readdata;
                buf_tag_d   = pend_tag_q;
                buf_valid_d = (READ_BUFFER != 0);
                rdata_d     = pend_half_q ? m_readdata[63:32] : m_readdata[31:0];
                rvalid_d    = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
            pend_half_q <= 1'b0;
            pend_tag_q  <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
            pend_half_q <= pend_half_d;
            pend_tag_q  <= pend_tag_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    // RAM side is held quiet, clock enable included, while in reset.
    assign m_chipselect    = reset_n & ram_cs;
    assign m_write         = reset_n & ram_we;
    assign m_byteenable    = ram_be & {8{reset_n}};
    assign m_address       = word_addr & {RAM_AW{reset_n}};
    assign m_writedata     = wdata_wide & {64{reset_n}};
    assign m_clken         = reset_n;
    assign s_waitrequest   = (state_q == ST_RD_WAIT);
    assign s_readdata      = rdata_q;
    assign s_readdatavalid = rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_scr1_ram_width_bridge.sv
// Bench for scr1_ram_width_bridge: buffered (index 1) and unbuffered (index 0)
// instances share stimulus; each has its own RAM and is checked every cycle.
`default_nettype none

module tb_scr1_ram_width_bridge;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW:0]   s_address;
    logic          s_read, s_write;
    logic [3:0]    s_be;
    logic [31:0]   s_wd;

    logic [31:0]   rd0, rd1;
    logic          rv0, rv1, wq0, wq1, cs0, cs1, we0, we1, ck0, ck1;
    logic [AW-1:0] ma0, ma1;
    logic [7:0]    be0, be1;
    logic [63:0]   wd0, wd1;
    logic [63:0]   mr0 = '0, mr1 = '0;

    bit [63:0] ram0 [1<<AW];
    bit [63:0] ram1 [1<<AW];

    always #5 clk = ~clk;

    scr1_ram_width_bridge #(.READ_BUFFER(1), .RAM_AW(AW)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .s_address(s_address), .s_read(s_read),
        .s_write(s_write), .s_byteenable(s_be), .s_writedata(s_wd),
        .s_readdata(rd1), .s_readdatavalid(rv1), .s_waitrequest(wq1),
        .m_address(ma1), .m_byteenable(be1), .m_chipselect(cs1), .m_write(we1),
        .m_writedata(wd1), .m_clken(ck1), .m_readdata(mr1));

    scr1_ram_width_bridge #(.READ_BUFFER(0), .RAM_AW(AW)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .s_address(s_address), .s_read(s_read),
        .s_write(s_write), .s_byteenable(s_be), .s_writedata(s_wd),
        .s_readdata(rd0), .s_readdatavalid(rv0), .s_waitrequest(wq0),
        .m_address(ma0), .m_byteenable(be0), .m_chipselect(cs0), .m_write(we0),
        .m_writedata(wd0), .m_clken(ck0), .m_readdata(mr0));

    always @(posedge clk) begin
        if (cs1) begin
            if (we1) begin
                for (int i = 0; i < 8; i++)
                    if (be1[i]) ram1[ma1][i*8 +: 8] <= wd1[i*8 +: 8];
            end else mr1 <= ram1[ma1];
        end
    end

    always @(posedge clk) begin
        if (cs0) begin
            if (we0) begin
                for (int i = 0; i < 8; i++)
                    if (be0[i]) ram0[ma0][i*8 +: 8] <= wd0[i*8 +: 8];
            end else mr0 <= ram0[ma0];
        end
    end

    // Scoreboard: expected memory image plus per-instance outstanding read
    bit [63:0]   mdl [1<<AW];
    int          checks = 0, errors = 0, cyc = 0;
    bit          pend [2], miss [2], bvalid [2];
    int          due [2], acc_cyc [2], meas_lat [2], rv_count [2];
    logic [31:0] pdata [2], meas_data [2];
    logic [AW-1:0] btag [2];
    logic        acc_cs [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int d, input logic rv, input logic [31:0] rd,
                             input logic wq, input logic [AW-1:0] ma, input logic [7:0] be,
                             input logic cs, input logic we, input logic [63:0] wd,
                             input logic ck);
        string p;
        bit exp_rv, in_wait, hit, exp_cs, exp_we;
        logic [AW-1:0] w;
        p = $sformatf("d%0d", d);
        w = s_address[AW:1];
        if (!reset_n) begin
            chk({p, "_rst_rv"}, rv, 0);
            chk({p, "_rst_rdata"}, rd, 0);
            chk({p, "_rst_wait"}, wq, 0);
            chk({p, "_rst_mout"}, {ma, be, cs, we, ck}, 0);
            chk({p, "_rst_wd"}, wd, 0);
            pend[d]   = 0;
            bvalid[d] = 0;
            return;
        end
        exp_rv  = pend[d] && (due[d] == cyc);
        in_wait = pend[d] && miss[d] && (due[d] == cyc + 1);
        chk({p, "_rvalid"}, rv, exp_rv);
        if (exp_rv && rv) chk({p, "_rdata"}, rd, pdata[d]);
        if (rv) begin
            meas_lat[d]  = cyc - acc_cyc[d];
            meas_data[d] = rd;
            rv_count[d]++;
        end
        if (exp_rv) pend[d] = 0;
        chk({p, "_waitreq"}, wq, in_wait);
        chk({p, "_clken"}, ck, 1);
        chk({p, "_maddr"}, ma, w);
        hit    = (d == 1) && bvalid[d] && (btag[d] == w);
        exp_cs = !in_wait && (s_write || (s_read && !hit));
        exp_we = !in_wait && s_write;
        chk({p, "_cs"}, cs, exp_cs);
        chk({p, "_we"}, we, exp_we);
        if (exp_we) begin
            chk({p, "_be"}, be, s_address[0] ? {s_be, 4'h0} : {4'h0, s_be});
            chk({p, "_wd"}, wd, {s_wd, s_wd});
        end
        if (!in_wait && (s_read || s_write)) begin
            acc_cyc[d] = cyc;
            acc_cs[d]  = cs;
            if (!s_write) begin
                pend[d]  = 1;
                miss[d]  = !hit;
                due[d]   = cyc + (hit ? 1 : 2);
                pdata[d] = s_address[0] ? mdl[w][63:32] : mdl[w][31:0];
                if (d == 1) begin
                    bvalid[d] = 1;
                    btag[d]   = w;
                end
            end
        end
    endtask

    task automatic compare_loop();
        int base;
        forever begin
            @(negedge clk);
            cyc++;
            check_dut(0, rv0, rd0, wq0, ma0, be0, cs0, we0, wd0, ck0);
            check_dut(1, rv1, rd1, wq1, ma1, be1, cs1, we1, wd1, ck1);
            if (reset_n && s_write) begin
                base = s_address[0] ? 32 : 0;
                for (int i = 0; i < 4; i++)
                    if (s_be[i]) mdl[s_address[AW:1]][base + i*8 +: 8] = s_wd[i*8 +: 8];
            end
        end
    endtask

    task automatic start(input logic rd, input logic wr, input logic [AW:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        @(posedge clk); #1;
        s_read = rd; s_write = wr; s_address = a; s_be = be; s_wd = wd;
    endtask

    task automatic stop();
        @(posedge clk); #1;
        s_read = 0; s_write = 0;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [AW:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        start(rd, wr, a, be, wd);
        stop();
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic read_expect(input string nm, input logic [AW:0] a, input logic [31:0] d1,
                               input int lat1, input logic [31:0] d0);
        issue(1, 0, a, 4'h0, 32'h0);
        settle();
        chk({nm, "_d1_data"}, meas_data[1], d1);
        chk({nm, "_d1_lat"}, meas_lat[1], lat1);
        chk({nm, "_d1_cs"}, acc_cs[1], (lat1 == 2));
        chk({nm, "_d0_data"}, meas_data[0], d0);
        chk({nm, "_d0_lat"}, meas_lat[0], 2);
    endtask

    initial begin
        int rvc;
        reset_n = 0; s_read = 1; s_write = 1; s_address = 14'h0005; s_be = 4'hF;
        s_wd = 32'h0BADF00D;
        fork compare_loop(); join_none
        repeat (3) @(posedge clk);
        #1;
        chk("rst_clken", ck1, 0);
        chk("rst_cs_with_req", cs1, 0);
        chk("rst_wait", wq1, 0);
        chk("rst_rv", rv1, 0);
        reset_n = 1; s_read = 0; s_write = 0;
        @(posedge clk); #1;
        chk("clken_after_rst", ck1, 1);

        read_expect("first", 14'h0100, 32'h0, 2, 32'h0);

        start(0, 1, 14'h0005, 4'b0011, 32'hAABBCCDD);
        #2;
        chk("w5_maddr", ma1, 13'h0002);
        chk("w5_be", be1, 8'h30);
        chk("w5_wd", wd1, 64'hAABBCCDD_AABBCCDD);
        chk("w5_we", we1, 1);
        chk("w5_wait", wq1, 0);
        stop();
        issue(0, 1, 14'h0004, 4'hF, 32'h33334444);
        issue(0, 1, 14'h0005, 4'hF, 32'h11112222);
        settle();

        start(1, 0, 14'h0004, 4'h0, 32'h0);
        stop();
        chk("rd4_stall", wq1, 1);
        settle();
        chk("rd4_data", meas_data[1], 32'h33334444);
        chk("rd4_lat", meas_lat[1], 2);
        read_expect("rd5_hit", 14'h0005, 32'h11112222, 1, 32'h11112222);

        issue(0, 1, 14'h0005, 4'b1000, 32'h99000000);
        read_expect("coh", 14'h0005, 32'h99112222, 1, 32'h99112222);

        issue(0, 1, 14'h0201, 4'hF, 32'hCAFEF00D);
        issue(1, 0, 14'h0200, 4'h0, 32'h0);
        issue(1, 0, 14'h0201, 4'h0, 32'h0);
        settle();
        chk("b2b_d1_data", meas_data[1], 32'hCAFEF00D);
        chk("b2b_d1_lat", meas_lat[1], 1);
        chk("b2b_d0_lat", meas_lat[0], 2);

        rvc = rv_count[1];
        issue(1, 1, 14'h0006, 4'hF, 32'h12345678);
        settle();
        chk("rw_no_rv", rv_count[1], rvc);
        read_expect("rw_rd", 14'h0006, 32'h12345678, 2, 32'h12345678);

        start(0, 1, 14'h3FFF, 4'hF, 32'hDEADBEEF);
        #2;
        chk("wrap_maddr", ma1, 13'h1FFF);
        chk("wrap_be", be1, 8'hF0);
        stop();
        read_expect("wrap_hi", 14'h3FFF, 32'hDEADBEEF, 2, 32'hDEADBEEF);
        read_expect("wrap_lo", 14'h3FFE, 32'h0, 1, 32'h0);

        rvc = rv_count[1];
        issue(1, 0, 14'h0100, 4'h0, 32'h0);
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        settle();
        chk("abort_no_rv", rv_count[1], rvc);
        read_expect("after_abort", 14'h0100, 32'h0, 2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule

`default_nettype wire
